// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dmem_pkg                                                |
// | Purpose: Shared types and helper functions for dmem_bytelane.    |
// |          Size encoding, byte-enable generation, alignment check  |
// |          and load extraction/extension. Helpers work on a 64-bit |
// |          word so one body serves both 32- and 64-bit memories.   |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  localparam int c_MAX_BYTES = 8;

  // Lane mask for an access of the given size starting at byte offset.
  function automatic logic [c_MAX_BYTES-1:0] byte_en(input size_e size,
                                                     input logic [2:0] offset);
    logic [c_MAX_BYTES-1:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  // Address must be a multiple of the access size.
  function automatic logic misaligned(input size_e size, input logic [2:0] offset);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = offset[0];
      SZ_W:    r = |offset[1:0];
      default: r = |offset[2:0];
    endcase
    return r;
  endfunction

  // Shift the addressed lanes down to the LSBs, then sign/zero extend.
  // A 32-bit memory truncates the result, so its word loads come out
  // full-width regardless of is_unsigned.
  function automatic logic [63:0] load_extend(input logic [63:0] word,
                                              input size_e       size,
                                              input logic [2:0]  offset,
                                              input logic        is_unsigned);
    logic [63:0] s;
    logic [63:0] r;
    s = word >> {offset, 3'b000};
    case (size)
      SZ_B:    r = is_unsigned ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      SZ_H:    r = is_unsigned ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      SZ_W:    r = is_unsigned ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rsp_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dmem_rsp_pipe                                           |
// | Purpose: DEPTH-stage register chain carrying response valid,     |
// |          error flag and data. Async active-low reset drops any   |
// |          response in flight.                                     |
// | Ports  : clk, rst_n        - clock / async active-low reset      |
// |          i_valid/i_err/i_data - response entering the chain      |
// |          o_valid/o_err/o_data - response leaving the chain       |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module dmem_rsp_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_err,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic             o_err,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_err;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_err[0]   <= i_err;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_err   = r_err[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dmem_bytelane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dmem_bytelane                                           |
// | Purpose: Byte-lane data memory with valid/ready request port,    |
// |          B/H/W(/D) accesses, sign/zero extension, misalignment   |
// |          detection and a registered read pipeline. Zero-fills    |
// |          the array after every reset before accepting requests.  |
// | Ports  : clk, rst_n          - clock / async active-low reset    |
// |          req_valid/req_ready - request handshake                 |
// |          req_we, req_size, req_unsigned, req_addr, req_wdata     |
// |          rsp_valid, rsp_rdata, rsp_err - one pulse per request   |
// |          init_done           - zero-fill complete                |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_DEPTH    = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int c_NB   = DATA_WIDTH / 8;
  localparam int c_OFF  = $clog2(c_NB);
  localparam int c_IDXW = $clog2(MEM_DEPTH);

  localparam logic [0:0] c_ST_INIT = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [0:0]       r_state;
  logic [c_IDXW-1:0] r_init_cnt;
  logic             r_init_done;

  // Request-stage capture; the response chain then adds READ_LATENCY
  // registers so a request accepted at edge N is presented at N+READ_LATENCY.
  logic                  r_req_valid;
  logic                  r_req_err;
  logic [DATA_WIDTH-1:0] r_req_data;

  logic                  w_accept;
  size_e                 w_size;
  logic [2:0]            w_off;
  logic [c_IDXW-1:0]     w_idx;
  logic                  w_err;
  logic [7:0]            w_be8;
  logic [DATA_WIDTH-1:0] w_wdata_sh;
  logic [DATA_WIDTH-1:0] w_rword;
  logic [63:0]           w_ext;
  logic [DATA_WIDTH-1:0] w_ldata;

  logic                  w_mem_we;
  logic [c_IDXW-1:0]     w_mem_idx;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [c_NB-1:0]       w_mem_be;

  logic                  w_unused;

  assign req_ready = (r_state == c_ST_RUN);
  assign init_done = r_init_done;
  assign w_accept  = req_valid & req_ready;

  assign w_size = size_e'(req_size);
  assign w_off  = 3'(req_addr[c_OFF-1:0]);
  // Upper address bits are dropped, so addresses wrap modulo MEM_DEPTH words.
  assign w_idx  = req_addr[c_OFF+c_IDXW-1:c_OFF];
  assign w_err  = misaligned(w_size, w_off) | ((w_size == SZ_D) && (DATA_WIDTH == 32));

  assign w_be8      = byte_en(w_size, w_off);
  assign w_wdata_sh = req_wdata << {w_off, 3'b000};

  // Combinational read sees the array before this edge's write.
  assign w_rword = r_mem[w_idx];
  assign w_ext   = load_extend(64'(w_rword), w_size, w_off, req_unsigned);
  assign w_ldata = w_ext[DATA_WIDTH-1:0];

  // Single write port shared by the zero-fill sequencer and stores.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_idx;
    w_mem_wdata = w_wdata_sh;
    w_mem_be    = w_be8[c_NB-1:0];
    if (r_state == c_ST_INIT) begin
      w_mem_we    = rst_n;
      w_mem_idx   = r_init_cnt;
      w_mem_wdata = '0;
      w_mem_be    = '1;
    end else if (w_accept && req_we && !w_err) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < c_NB; b++) begin
      if (w_mem_we && w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        c_ST_INIT: begin
          if (r_init_cnt == c_IDXW'(MEM_DEPTH - 1)) begin
            r_state     <= c_ST_RUN;
            r_init_cnt  <= '0;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        default: r_state <= c_ST_RUN;
      endcase
    end
  end

  // Data and error are forced to 0 whenever no response is carried, so the
  // outputs read 0 outside rsp_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_err   <= 1'b0;
      r_req_data  <= '0;
    end else begin
      r_req_valid <= w_accept;
      r_req_err   <= w_accept & w_err;
      r_req_data  <= (w_accept && !req_we && !w_err) ? w_ldata : '0;
    end
  end

  dmem_rsp_pipe #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (READ_LATENCY)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_req_valid),
    .i_err   (r_req_err),
    .i_data  (r_req_data),
    .o_valid (rsp_valid),
    .o_err   (rsp_err),
    .o_data  (rsp_rdata)
  );

  assign w_unused = ^{req_addr[ADDR_WIDTH-1:c_OFF+c_IDXW], w_be8, w_ext};

endmodule
`default_nettype wire

// File: tb/tb_dmem_bytelane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_dmem_bytelane                                        |
// | Purpose: Scoreboard bench for dmem_bytelane (32-bit, 64 words,   |
// |          read latency 3). A byte-array reference model produces  |
// |          expected responses; a monitor compares them in order.   |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module tb_dmem_bytelane;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MD = 64;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  dmem_bytelane #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .MEM_DEPTH    (MD),
    .READ_LATENCY (RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          at;
    string       name;
  } exp_t;

  exp_t        sb[$];
  byte unsigned mem_m [MD*4];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MD*4; i++) mem_m[i] = 8'h00;
  endtask

  // Drive one request for the next edge and record the model's answer.
  task automatic issue(input bit we, input bit [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd, input string nm);
    int nb, base;
    bit e;
    logic [31:0] v;
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    nb   = 1 << sz;
    e    = (sz == 2'd3) || ((addr % nb) != 0);
    base = int'(addr % (MD*4));
    v    = '0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mem_m[base+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) v = v | (32'(mem_m[base+i]) << (8*i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 1);
      end
    end
    sb.push_back('{data: (we || e) ? 32'd0 : v, err: e, at: cyc + 1 + RL, name: nm});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_cycles"}, 32'(n), 32'(MD));
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Monitor: every response is matched in order against the scoreboard,
  // including the cycle it appears on; idle outputs must read 0.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 with data %h expected no response", rsp_rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_rdata !== e.data || rsp_err !== e.err || cyc != e.at) begin
            errors++;
            $display("FAIL %s: got data %h err %0d cycle %0d expected data %h err %0d cycle %0d",
                     e.name, rsp_rdata, rsp_err, cyc, e.data, e.err, e.at);
          end
        end
      end else begin
        checks++;
        if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got data %h err %0d expected 0 0", rsp_rdata, rsp_err);
        end
      end
    end
  end

  initial begin
    int n;
    bit [1:0] sz;
    logic [31:0] a;
    model_clear();

    #3 rst_n = 1'b0;
    #1;
    mon_en = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_init("init");

    // Freshly zeroed memory
    issue(0, 2'd2, 0, 32'h10, 0, "lw_after_init");

    // Extension cases
    issue(1, 2'd2, 0, 32'h20, 32'h80FF7F01, "sw_20");
    issue(0, 2'd0, 0, 32'h23, 0, "lb_23");
    issue(0, 2'd0, 1, 32'h23, 0, "lbu_23");
    issue(0, 2'd1, 0, 32'h22, 0, "lh_22");
    issue(0, 2'd1, 1, 32'h20, 0, "lhu_20");

    // Partial store
    issue(1, 2'd2, 0, 32'h40, 32'h11223344, "sw_40");
    issue(1, 2'd0, 0, 32'h41, 32'h000000AA, "sb_41");
    issue(0, 2'd2, 0, 32'h40, 0, "lw_40");

    // Errors, and memory left untouched by the rejected store
    issue(0, 2'd1, 0, 32'h01, 0, "lh_misaligned");
    issue(1, 2'd2, 0, 32'h42, 32'hDEADBEEF, "sw_misaligned");
    issue(0, 2'd2, 0, 32'h40, 0, "lw_40_unchanged");
    issue(0, 2'd3, 0, 32'h48, 0, "dword_illegal");
    idle(2);

    // Back-to-back loads with address wrap
    issue(1, 2'd2, 0, 32'h00, 32'hCAFEBABE, "sw_00");
    issue(0, 2'd2, 0, 32'h100, 0, "b2b_wrap_100");
    issue(0, 2'd2, 0, 32'h20, 0, "b2b_20");
    issue(0, 2'd0, 1, 32'h21, 0, "b2b_21");
    issue(0, 2'd2, 0, 32'h40, 0, "b2b_40");
    issue(0, 2'd1, 0, 32'h102, 0, "b2b_102");
    issue(0, 2'd2, 0, 32'h1F0, 0, "b2b_1f0");
    issue(0, 2'd0, 0, 32'h120, 0, "b2b_120");
    issue(0, 2'd2, 0, 32'hFFFFFF40, 0, "b2b_wrap_high");
    idle(2);

    // Randomized mix
    for (int k = 0; k < 400; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rand");
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(RL + 4);

    // Reset with two responses in flight
    issue(0, 2'd2, 0, 32'h20, 0, "inflight_a");
    issue(0, 2'd2, 0, 32'h40, 0, "inflight_b");
    @(posedge clk); #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    model_clear();
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_init("reinit");
    issue(0, 2'd2, 0, 32'h20, 0, "lw_20_after_reset");
    issue(0, 2'd2, 0, 32'h40, 0, "lw_40_after_reset");
    issue(0, 2'd2, 0, 32'h00, 0, "lw_00_after_reset");
    idle(1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
